root_reconstruct: RTL
=====================

// Module: root_reconstruct
// PURPOSE
//  Sequential shift-add squarer that inverts the integer square-root unit: from a root q and
//  remainder r it rebuilds the radicand d = q*q + r, one multiplier bit per clock.
//  Sits beside the root unit as a self-check / round-trip path; port style and
//  load/busy/ready/count handshake match the root unit's so both drop into the same bench.
// PARAMETERS
//  QW  16  root width; remainder width QW+1, radicand width 2*QW
//  CW   4  iteration-counter width; 2**CW must equal QW
// PORTS
//  clk    in   1      clock, all state on rising edge
//  clrn   in   1      asynchronous active-low reset
//  q      in   QW     root operand, sampled on load
//  r      in   QW+1   remainder operand, sampled on load
//  load   in   1      start request, sampled on rising clk
//  d      out  2*QW   reconstructed radicand (low 2*QW bits of q*q+r)
//  ovf    out  1      q*q+r exceeded 2*QW bits (bit 2*QW of the sum)
//  err    out  1      non-canonical remainder: r > 2*q
//  busy   out  1      iteration in progress
//  ready  out  1      one-cycle pulse: d/ovf valid
//  count  out  CW     current iteration index
// BEHAVIOUR
//  - Reset (clrn=0, async): d=0, ovf=0, err=0, busy=0, ready=0, count=0, FSM=IDLE.
//    Reset mid-operation aborts the operation; no ready pulse follows.
//  - FSM: IDLE --load--> RUN. RUN, count==QW-1 --> IDLE, pulse ready. load in any state --> RUN.
//  - Load edge: q_reg<=q, mplr<=q, acc<=zero-ext(r) to 2*QW+1 bits, err<=(r > {q,1'b0}),
//    ovf<=0, count<=0, busy<=1, ready<=0. d is not changed by load.
//  - RUN, each edge: if mplr[0], acc<=acc + (q_reg << count); mplr<=mplr>>1; count<=count+1.
//    Internal acc is 2*QW+1 bits wide; the add never truncates.
//  - Final RUN edge (count==QW-1, i.e. QW-th edge after load): d<=acc_next[2*QW-1:0],
//    ovf<=acc_next[2*QW], busy<=0, ready<=1, count wraps to 0.
//  - Latency: ready=1 in the cycle after the QW-th rising edge following the load edge
//    (16 cycles for QW=16). ready lasts exactly one cycle.
//  - d, ovf, err hold until the next load or reset.
//  - load while busy: operands resampled, count restarts at 0, no ready for the aborted operation.
//  - load in the same cycle ready=1: accepted; ready drops next cycle, new operation starts.
//  - err is informational only: the computation still runs, and ovf can be 1 only when err=1.
//  - q=0: all adds are skipped; d=r.
// TESTING
//  1 q=16'hddb3, r=17'h174d7, load 1 cycle -> busy 16 cycles, ready pulse, d=32'hc0000000, err=0, ovf=0
//  2 q=0, r=0 -> d=0, err=0, ovf=0, ready after 16 cycles; count steps 0..15 then back to 0
//  3 q=16'hffff, r=17'h1fffe -> d=32'hffffffff, err=0, ovf=0
//  4 q=16'hffff, r=17'h1ffff -> err=1 from the cycle after load, d=32'h00000000, ovf=1
//  5 load q=3,r=2; at count=7 reload q=16'h0100, r=0 -> one ready pulse only, 16 cycles after reload, d=32'h00010000
//  6 load q=16'h1234, r=5; drop clrn at count=9 -> all outputs 0 at once, no ready; next load completes normally

Source files
------------

// File: rtl/root_reconstruct.sv
// Shift-add squarer rebuilding d = q*q + r one multiplier bit per clock; ready pulses QW cycles after load.
// No backpressure: load is accepted in any state and restarts the operation.
module root_reconstruct #(
    parameter int QW = 16,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [QW-1:0]   q,
    input  logic [QW:0]     r,
    input  logic            load,
    output logic [2*QW-1:0] d,
    output logic            ovf,
    output logic            err,
    output logic            busy,
    output logic            ready,
    output logic [CW-1:0]   count
);
    localparam int AW = 2*QW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [QW-1:0]   r_q;
    logic [QW-1:0]   r_mplr;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   w_addend;
    logic [AW-1:0]   w_acc_next;
    logic            w_last;

    // Partial product for the current bit; the accumulator is one bit wider than d so the add never truncates.
    assign w_addend   = {{(QW+1){1'b0}}, r_q} << count;
    assign w_acc_next = r_mplr[0] ? (r_acc + w_addend) : r_acc;

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        if (load) begin
            w_state_next = RUN;
        end else if (r_state == RUN && count == CW'(QW-1)) begin
            w_state_next = IDLE;
            w_last       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_q    <= '0;
            r_mplr <= '0;
            r_acc  <= '0;
            d      <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            count  <= '0;
        end else if (load) begin
            r_q    <= q;
            r_mplr <= q;
            r_acc  <= {{QW{1'b0}}, r};
            err    <= (r > {q, 1'b0});
            ovf    <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            ready  <= 1'b0;
        end else if (r_state == RUN) begin
            r_acc  <= w_acc_next;
            r_mplr <= r_mplr >> 1;
            count  <= count + 1'b1;
            ready  <= 1'b0;
            if (w_last) begin
                d     <= w_acc_next[2*QW-1:0];
                ovf   <= w_acc_next[2*QW];
                busy  <= 1'b0;
                ready <= 1'b1;
            end
        end else begin
            ready <= 1'b0;
        end
    end

endmodule
